// File: rtl/fetch_bus_if_if.sv
// Fetch-side bus bundle between the fetch master and the arbiter/decoder/ROM path.
// Carries request/grant, address strobe, read/write flag, read data and slave ready.
interface fetch_bus_if_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              m_req;
  logic              m_grnt;
  logic [ADDR_W-1:0] m_addr;
  logic              m_as;
  logic              m_rw;
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rdy;

  modport master (
    output m_req, m_addr, m_as, m_rw,
    input  m_grnt, m_rd_data, m_rdy
  );

  modport slave (
    input  m_req, m_addr, m_as, m_rw,
    output m_grnt, m_rd_data, m_rdy
  );
endinterface

// File: rtl/fetch_bus_if.sv
// Read-only bus master for the instruction-fetch stage, with stall hold and flush kill.
// Optional access timeout enabled by defining FETCH_BUS_TIMEOUT_EN.
module fetch_bus_if #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              bus_err,
  fetch_bus_if_if.master    bus
);

  typedef enum logic [1:0] {StIdle, StReq, StAccess, StStall} state_e;

  state_e            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_as_q, m_as_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              bus_err_q, bus_err_d;
  logic              kill_q, kill_d;
  logic              killed;
  logic              timeout;

  // A flush on the ready cycle itself kills the access too.
  assign killed = kill_q | flush;

`ifdef FETCH_BUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == StAccess) && !bus.m_rdy && (cnt_q == CntW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StReq && !flush && bus.m_grnt) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !bus.m_rdy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_as_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_as_q     <= m_as_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
      kill_q     <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (if_req && !flush) state_d = StReq;
      end
      StReq: begin
        if (flush)            state_d = StIdle;
        else if (bus.m_grnt)  state_d = StAccess;
      end
      StAccess: begin
        if (bus.m_rdy)        state_d = (!killed && stall) ? StStall : StIdle;
        else if (timeout)     state_d = StIdle;
      end
      StStall: begin
        if (!stall)           state_d = StIdle;
      end
      default:                state_d = StIdle;
    endcase
  end

  always_comb begin
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    m_as_d     = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    bus_err_d  = 1'b0;
    kill_d     = kill_q;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = if_req && !flush;
        if (rd_valid_q && !stall) rd_valid_d = 1'b0;
        if (if_req && !flush) begin
          m_req_d  = 1'b1;
          m_addr_d = if_addr;
        end
      end
      StReq: begin
        busy = 1'b1;
        if (flush) begin
          m_req_d = 1'b0;
        end else if (bus.m_grnt) begin
          m_as_d = 1'b1;
          kill_d = 1'b0;
        end
      end
      StAccess: begin
        busy = 1'b1;
        if (flush) kill_d = 1'b1;
        if (bus.m_rdy) begin
          rd_data_d  = bus.m_rd_data;
          m_req_d    = 1'b0;
          rd_valid_d = ~killed;
        end else if (timeout) begin
          rd_data_d  = '0;
          m_req_d    = 1'b0;
          rd_valid_d = ~killed;
          bus_err_d  = 1'b1;
        end
      end
      StStall: begin
        busy = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus.m_req  = m_req_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_as   = m_as_q;
  assign bus.m_rw   = 1'b1;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_fetch_bus_if.sv
// Directed bench for fetch_bus_if: a registered ROM model answers each address strobe,
// expected words go through a scoreboard queue and are compared on capture.
module tb_fetch_bus_if;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              bus_err;
  logic              grnt = 1'b0;
  logic              rom_on = 1'b1;
  logic [DATA_W-1:0] rom_word = '0;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] sb_q[$];

  fetch_bus_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .stall    (stall),
    .flush    (flush),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .bus_err  (bus_err),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.m_grnt = grnt;

  // ROM slave: ready and data registered one cycle after the strobe.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.m_rdy     <= 1'b0;
      bus.m_rd_data <= '0;
    end else begin
      bus.m_rdy     <= bus.m_as && rom_on;
      bus.m_rd_data <= rom_word;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop_check(input string tag);
    logic [DATA_W-1:0] exp;
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_rd_data"}, 64'(rd_data), 64'(exp));
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rd_valid) break;
    end
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd1);
    if (rd_valid) sb_pop_check(tag);
  endtask

  task automatic start_fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w,
                             input bit expect_data);
    if_req   = 1'b1;
    if_addr  = a;
    rom_word = w;
    if (expect_data) sb_q.push_back(w);
    #1;
    check("start_busy", 64'(busy), 64'd1);
    tick();
    if_req = 1'b0;
    check("req_m_req", 64'(bus.m_req), 64'd1);
    check("req_m_addr", 64'(bus.m_addr), 64'(a));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_m_req", 64'(bus.m_req), 64'd0);
    check("rst_m_as", 64'(bus.m_as), 64'd0);
    check("rst_m_rw", 64'(bus.m_rw), 64'd1);
    check("rst_m_addr", 64'(bus.m_addr), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: immediate grant, ROM ready next cycle, capture on edge 4
    grnt = 1'b1;
    start_fetch(30'h10, 32'h1234_5678, 1'b1);
    tick();
    check("t1_m_as_hi", 64'(bus.m_as), 64'd1);
    check("t1_rv_e2", 64'(rd_valid), 64'd0);
    tick();
    check("t1_m_as_lo", 64'(bus.m_as), 64'd0);
    check("t1_rv_e3", 64'(rd_valid), 64'd0);
    check("t1_addr_stable", 64'(bus.m_addr), 64'h10);
    tick();
    check("t1_rv_e4", 64'(rd_valid), 64'd1);
    if (rd_valid) sb_pop_check("t1");
    check("t1_m_req_drop", 64'(bus.m_req), 64'd0);
    check("t1_busy_lo", 64'(busy), 64'd0);
    check("t1_bus_err", 64'(bus_err), 64'd0);
    tick();
    check("t1_rv_clear", 64'(rd_valid), 64'd0);

    // 2: grant delayed by 5 cycles
    grnt = 1'b0;
    start_fetch(30'h20, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_m_req_held", 64'(bus.m_req), 64'd1);
      check("t2_no_as", 64'(bus.m_as), 64'd0);
      check("t2_busy", 64'(busy), 64'd1);
    end
    grnt = 1'b1;
    tick();
    check("t2_m_as", 64'(bus.m_as), 64'd1);
    check("t2_busy_acc", 64'(busy), 64'd1);
    wait_valid("t2", 6);
    tick();

    // 3: stall held for 3 cycles from capture
    start_fetch(30'h30, 32'h0BAD_BEEF, 1'b1);
    tick();
    tick();
    stall = 1'b1;
    tick();
    check("t3_rv", 64'(rd_valid), 64'd1);
    if (rd_valid) sb_pop_check("t3");
    rom_word = 32'hFFFF_0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_hold_rv", 64'(rd_valid), 64'd1);
      check("t3_hold_data", 64'(rd_data), 64'h0BAD_BEEF);
      check("t3_busy_lo", 64'(busy), 64'd0);
    end
    stall = 1'b0;
    tick();
    // busy only follows if_req from IDLE, so this shows STALL was left on this edge
    if_req  = 1'b1;
    if_addr = 30'h60;
    rom_word = 32'h600D_CAFE;
    sb_q.push_back(32'h600D_CAFE);
    #1;
    check("t3_idle_busy", 64'(busy), 64'd1);
    tick();
    if_req = 1'b0;
    check("t3_rv_drop", 64'(rd_valid), 64'd0);
    check("t3b_addr", 64'(bus.m_addr), 64'h60);
    wait_valid("t3b", 6);
    tick();

    // 4a: flush one cycle after the strobe; cycle completes, data dropped
    start_fetch(30'h40, 32'hDEAD_0040, 1'b0);
    tick();
    check("t4_m_as", 64'(bus.m_as), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_req_held", 64'(bus.m_req), 64'd1);
    tick();
    check("t4_m_req_drop", 64'(bus.m_req), 64'd0);
    check("t4_rv_lo", 64'(rd_valid), 64'd0);
    tick();
    check("t4_rv_lo2", 64'(rd_valid), 64'd0);

    // 4b: flush while waiting for grant
    grnt = 1'b0;
    start_fetch(30'h44, 32'hDEAD_0044, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    grnt  = 1'b1;
    check("t4b_m_req_drop", 64'(bus.m_req), 64'd0);
    check("t4b_no_as", 64'(bus.m_as), 64'd0);
    tick();
    check("t4b_no_as2", 64'(bus.m_as), 64'd0);
    check("t4b_rv_lo", 64'(rd_valid), 64'd0);

    // flush and if_req together in IDLE: flush wins
    if_req = 1'b1;
    flush  = 1'b1;
    #1;
    check("fl_busy", 64'(busy), 64'd0);
    tick();
    check("fl_no_req", 64'(bus.m_req), 64'd0);
    if_req = 1'b0;
    flush  = 1'b0;

    // 5: reset asserted during ACCESS
    start_fetch(30'h50, 32'hAAAA_5555, 1'b0);
    tick();
    check("t5_m_as", 64'(bus.m_as), 64'd1);
    reset = 1'b0;
    #1;
    check("t5_m_req", 64'(bus.m_req), 64'd0);
    check("t5_m_as0", 64'(bus.m_as), 64'd0);
    check("t5_m_addr", 64'(bus.m_addr), 64'd0);
    check("t5_m_rw", 64'(bus.m_rw), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_rv", 64'(rd_valid), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t5_idle_rv", 64'(rd_valid), 64'd0);
    start_fetch(30'h58, 32'h5858_5858, 1'b1);
    wait_valid("t5b", 6);
    tick();

`ifdef FETCH_BUS_TIMEOUT_EN
    // 6: slave never ready
    rom_on = 1'b0;
    start_fetch(30'h70, 32'h7777_7777, 1'b0);
    sb_q.push_back(32'h0);
    begin
      int n = 0;
      while (!bus_err && n < 20) begin
        tick();
        n++;
      end
    end
    check("t6_bus_err", 64'(bus_err), 64'd1);
    check("t6_rv", 64'(rd_valid), 64'd1);
    check("t6_m_req", 64'(bus.m_req), 64'd0);
    if (rd_valid) sb_pop_check("t6");
    tick();
    check("t6_err_pulse", 64'(bus_err), 64'd0);
    rom_on = 1'b1;
    tick();
`endif

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
